divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 23 ++
 rtl/divider.sv | 121 ++++++++++++
 tb/tb_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the signed restoring divider: state encoding,
// default operand width and the iteration-counter width.
package div_pkg;

  localparam int DIV_WIDTH = 64;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes:
// shift the next dividend bit into the partial remainder, trial-subtract.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] shifted;
  logic       ge;

  // quo_in carries the not-yet-consumed dividend bits in its upper end and
  // collects quotient bits at the bottom as they shift out.
  assign shifted = {rem_in, quo_in[W-1]};
  assign ge      = shifted >= {1'b0, divisor};
  assign rem_out = ge ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];
  assign quo_out = {quo_in[W-2:0], ge};

endmodule

// File: rtl/divider.sv
// Signed multi-cycle divider: magnitudes go through WIDTH restoring steps,
// then a single fix-up cycle applies signs and publishes {remainder, quotient}.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               op_done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t         state_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   dvsr_reg;
  logic               neg_quo_reg;
  logic               neg_rem_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               done_reg;
  logic               dbz_reg;

  logic [WIDTH-1:0]   dividend_abs;
  logic [WIDTH-1:0]   divisor_abs;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  // The most negative value negates to itself, which read unsigned is its magnitude.
  assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;

  div_step #(.W(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (dvsr_reg),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvsr_reg    <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
    end else if (op_clear) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvsr_reg    <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (op_start) begin
            if (divisor == '0) begin
              result_reg <= {dividend, {WIDTH{1'b1}}};
              done_reg   <= 1'b1;
              dbz_reg    <= 1'b1;
              state_reg  <= ST_DONE;
            end else begin
              rem_reg     <= '0;
              quo_reg     <= dividend_abs;
              dvsr_reg    <= divisor_abs;
              neg_quo_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_rem_reg <= dividend[WIDTH-1];
              count_reg   <= '0;
              state_reg   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rem_reg   <= rem_step;
          quo_reg   <= quo_step;
          count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
          if (count_reg == LAST) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_reg <= {(neg_rem_reg ? -rem_reg : rem_reg),
                         (neg_quo_reg ? -quo_reg : quo_reg)};
          done_reg   <= 1'b1;
          state_reg  <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_DONE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_done     = done_reg;
  assign div_by_zero = dbz_reg;
  assign result      = result_reg;

endmodule

// File: tb/tb_divider.sv
// Randomised self-checking bench for divider against a plain-arithmetic
// signed division model, plus the directed corner scenarios.
module tb_divider;

  localparam int W = 64;
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic               clk;
  logic               reset;
  logic               op_start;
  logic               op_clear;
  logic signed [W-1:0] dividend;
  logic signed [W-1:0] divisor;
  logic               op_done;
  logic               div_by_zero;
  logic [2*W-1:0]     result;

  int n_cmp = 0;
  int n_bad = 0;

  divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .dividend    (dividend),
    .divisor     (divisor),
    .op_done     (op_done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Truncating signed division; remainder follows the dividend's sign.
  function automatic logic [2*W-1:0] ref_div(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [W-1:0] q;
    logic signed [W-1:0] r;
    if (b == 0) begin
      q = -1;
      r = a;
    end else if (a == MIN_VAL && b == -1) begin
      q = MIN_VAL;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic expect_cleared(input string tag);
    check({tag, "_done"}, 128'(op_done), 128'd0);
    check({tag, "_result"}, result, 128'd0);
    check({tag, "_dbz"}, 128'(div_by_zero), 128'd0);
  endtask

  // Full transaction: start, measure latency from E0, check, hold, clear.
  task automatic do_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input string tag);
    logic [2*W-1:0] exp;
    int n;
    int exp_lat;
    exp = ref_div(a, b);
    exp_lat = (b == 0) ? 0 : 65;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    op_clear = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
    while (!op_done && n < 200) begin
      if (n == 10) check({tag, "_partial_hidden"}, result, 128'd0);
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_dbz"}, 128'(div_by_zero), 128'(b == 0));
    $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d",
             tag, a, b, $signed(result[W-1:0]), $signed(result[2*W-1:W]), div_by_zero, n);
    // op_start stays high and operands change; DONE must hold.
    @(negedge clk);
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_result"}, result, exp);
    check({tag, "_hold_done"}, 128'(op_done), 128'd1);
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    expect_cleared({tag, "_clr"});
    @(negedge clk);
    op_clear = 1'b0;
  endtask

  initial begin
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    int mode;

    reset    = 1'b1;
    op_start = 1'b0;
    op_clear = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    expect_cleared("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_op(64'sd100, 64'sd7, "100div7");
    do_op(-64'sd7, 64'sd2, "m7div2");
    do_op(64'sd7, -64'sd2, "7divm2");
    do_op(64'sd5, 64'sd0, "5div0");
    do_op(MIN_VAL, -64'sd1, "overflow");
    do_op(MIN_VAL, 64'sd1, "min_div1");
    do_op(64'sd3, 64'sd9, "small_num");

    // Abort 30 cycles into EXEC, then a fresh operation.
    @(negedge clk);
    dividend = 64'sd100;
    divisor  = 64'sd7;
    op_start = 1'b1;
    repeat (31) @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    expect_cleared("abort");
    @(negedge clk);
    op_clear = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("abort_no_done", 128'(op_done), 128'd0);
    do_op(64'sd25, 64'sd5, "25div5");

    // Reset asserted between edges while in DONE must clear outputs at once.
    @(negedge clk);
    dividend = 64'sd9;
    divisor  = 64'sd0;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_done", 128'(op_done), 128'd1);
    #2;
    reset = 1'b1;
    #1;
    expect_cleared("async_reset");
    @(negedge clk);
    reset = 1'b0;
    op_start = 1'b0;

    // Reset mid-EXEC, then op_start held together with op_clear.
    @(negedge clk);
    dividend = 64'sd100;
    divisor  = 64'sd7;
    op_start = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_cleared("mid_exec_reset");
    @(negedge clk);
    reset    = 1'b0;
    op_clear = 1'b1;
    dividend = 64'sd10;
    divisor  = 64'sd3;
    repeat (80) @(posedge clk);
    #1;
    check("clear_blocks_start", 128'(op_done), 128'd0);
    do_op(64'sd10, 64'sd3, "10div3");

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (mode)
        1: begin
          a = $signed(64'($urandom_range(0, 2000))) - 64'sd1000;
          b = $signed(64'($urandom_range(0, 40))) - 64'sd20;
        end
        2: b = 64'sd0;
        3: b = $signed(64'($urandom_range(0, 200))) - 64'sd100;
        default: ;
      endcase
      do_op(a, b, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
